// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary register with a valid/ready handshake, flush, and an
// optional 2-entry skid buffer that registers EX_ready.
module ex_mem_stage #(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int RW   = 5,
  parameter int WBW  = 2,
  parameter int MW   = 3,
  parameter int SKID = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           EX_valid,
  output logic           EX_ready,
  input  logic [AW-1:0]  EX_bpc,
  input  logic [DW-1:0]  EX_alu_out,
  input  logic [DW-1:0]  EX_rd2,
  input  logic [WBW-1:0] EX_ctlwb,
  input  logic [MW-1:0]  EX_ctlm,
  input  logic           EX_alu_zero,
  input  logic [RW-1:0]  EX_rd_mux,
  input  logic           MEM_ready,
  output logic           MEM_valid,
  output logic [AW-1:0]  MEM_bpc,
  output logic [DW-1:0]  MEM_alu_out,
  output logic [DW-1:0]  MEM_rd2,
  output logic [WBW-1:0] MEM_ctlwb,
  output logic [MW-1:0]  MEM_ctlm,
  output logic           MEM_alu_zero,
  output logic [RW-1:0]  MEM_rd
);

  localparam int PW = AW + 2 * DW + WBW + MW + 1 + RW;

  logic [PW-1:0]  in_word;
  logic [PW-1:0]  main_q;
  logic           valid_q;
  logic [WBW-1:0] ctlwb_q;
  logic [MW-1:0]  ctlm_q;

  assign in_word = {EX_bpc, EX_alu_out, EX_rd2, EX_ctlwb, EX_ctlm, EX_alu_zero, EX_rd_mux};
  assign {MEM_bpc, MEM_alu_out, MEM_rd2, ctlwb_q, ctlm_q, MEM_alu_zero, MEM_rd} = main_q;

  // Control is masked on bubbles so MEM never acts on stale control bits.
  assign MEM_valid = valid_q;
  assign MEM_ctlwb = valid_q ? ctlwb_q : '0;
  assign MEM_ctlm  = valid_q ? ctlm_q  : '0;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

      state_t        state_q, state_d;
      logic [PW-1:0] skid_q;
      logic          accept, pop;
      logic          load_main_in, load_main_skid, load_skid;

      // Ready depends only on registered state (and rst), never on MEM_ready.
      assign EX_ready = !rst && (state_q != FULL);
      assign valid_q  = (state_q != EMPTY);
      assign accept   = EX_valid && EX_ready;
      assign pop      = valid_q && MEM_ready;

      always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
          EMPTY: begin
            if (accept) begin
              state_d      = ONE;
              load_main_in = 1'b1;
            end
          end
          ONE: begin
            if (accept && pop) begin
              load_main_in = 1'b1;
            end else if (accept) begin
              state_d   = FULL;
              load_skid = 1'b1;
            end else if (pop) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (pop) begin
              state_d        = ONE;
              load_main_skid = 1'b1;
            end
          end
          default: state_d = EMPTY;
        endcase
        if (flush) begin
          state_d        = EMPTY;
          load_main_in   = 1'b0;
          load_main_skid = 1'b0;
          load_skid      = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= EMPTY;
          main_q  <= '0;
        end else begin
          state_q <= state_d;
          if (load_main_in) begin
            main_q <= in_word;
          end else if (load_main_skid) begin
            main_q <= skid_q;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst && load_skid) begin
          skid_q <= in_word;
        end
      end
    end else begin : g_single
      logic accept, pop;

      assign EX_ready = !rst && (!valid_q || MEM_ready);
      assign accept   = EX_valid && EX_ready;
      assign pop      = valid_q && MEM_ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (accept) begin
          valid_q <= 1'b1;
          main_q  <= in_word;
        end else if (pop) begin
          valid_q <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: a skid instance and a single-register instance share
// stimulus and are checked against queue-based reference models.
module tb_ex_mem_stage;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int RW  = 5;
  localparam int WBW = 2;
  localparam int MW  = 3;
  localparam int PW  = AW + 2 * DW + WBW + MW + 1 + RW;
  localparam int CTL_LO = RW + 1;
  localparam int CTL_HI = RW + 1 + MW + WBW - 1;

  logic           clk, rst, flush, ex_valid, mem_ready;
  logic [AW-1:0]  ex_bpc;
  logic [DW-1:0]  ex_alu_out, ex_rd2;
  logic [WBW-1:0] ex_ctlwb;
  logic [MW-1:0]  ex_ctlm;
  logic           ex_alu_zero;
  logic [RW-1:0]  ex_rd;

  logic           rdy1, v1, z1, rdy0, v0, z0;
  logic [AW-1:0]  bpc1, bpc0;
  logic [DW-1:0]  alu1, rd21, alu0, rd20;
  logic [WBW-1:0] wb1, wb0;
  logic [MW-1:0]  m1, m0;
  logic [RW-1:0]  rd1, rd0;

  int unsigned n_cmp, n_fail;

  logic [PW-1:0] q1[$];
  logic [PW-1:0] q0[$];
  logic [PW-1:0] last1, last0;

  ex_mem_stage #(.DW(DW), .AW(AW), .RW(RW), .WBW(WBW), .MW(MW), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .EX_valid(ex_valid), .EX_ready(rdy1),
    .EX_bpc(ex_bpc), .EX_alu_out(ex_alu_out), .EX_rd2(ex_rd2), .EX_ctlwb(ex_ctlwb),
    .EX_ctlm(ex_ctlm), .EX_alu_zero(ex_alu_zero), .EX_rd_mux(ex_rd), .MEM_ready(mem_ready),
    .MEM_valid(v1), .MEM_bpc(bpc1), .MEM_alu_out(alu1), .MEM_rd2(rd21), .MEM_ctlwb(wb1),
    .MEM_ctlm(m1), .MEM_alu_zero(z1), .MEM_rd(rd1)
  );

  ex_mem_stage #(.DW(DW), .AW(AW), .RW(RW), .WBW(WBW), .MW(MW), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .EX_valid(ex_valid), .EX_ready(rdy0),
    .EX_bpc(ex_bpc), .EX_alu_out(ex_alu_out), .EX_rd2(ex_rd2), .EX_ctlwb(ex_ctlwb),
    .EX_ctlm(ex_ctlm), .EX_alu_zero(ex_alu_zero), .EX_rd_mux(ex_rd), .MEM_ready(mem_ready),
    .MEM_valid(v0), .MEM_bpc(bpc0), .MEM_alu_out(alu0), .MEM_rd2(rd20), .MEM_ctlwb(wb0),
    .MEM_ctlm(m0), .MEM_alu_zero(z0), .MEM_rd(rd0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [PW:0] obs1();
    return {v1, bpc1, alu1, rd21, wb1, m1, z1, rd1};
  endfunction

  function automatic logic [PW:0] obs0();
    return {v0, bpc0, alu0, rd20, wb0, m0, z0, rd0};
  endfunction

  function automatic logic [PW-1:0] in_word();
    return {ex_bpc, ex_alu_out, ex_rd2, ex_ctlwb, ex_ctlm, ex_alu_zero, ex_rd};
  endfunction

  function automatic logic [PW:0] shown(input logic v, input logic [PW-1:0] w);
    logic [PW-1:0] m;
    m = w;
    if (!v) m[CTL_HI:CTL_LO] = '0;
    return {v, m};
  endfunction

  function automatic logic [PW:0] exp1();
    return (q1.size() > 0) ? shown(1'b1, q1[0]) : shown(1'b0, last1);
  endfunction

  function automatic logic [PW:0] exp0();
    return (q0.size() > 0) ? shown(1'b1, q0[0]) : shown(1'b0, last0);
  endfunction

  function automatic logic exp_rdy1();
    return !rst && (q1.size() < 2);
  endfunction

  function automatic logic exp_rdy0();
    return !rst && (q0.size() == 0 || mem_ready);
  endfunction

  task automatic set_in(input logic r, input logic fl, input logic ev, input logic mr,
                        input logic [DW-1:0] alu);
    rst = r; flush = fl; ex_valid = ev; mem_ready = mr; ex_alu_out = alu;
  endtask

  task automatic set_payload(input logic [AW-1:0] b, input logic [DW-1:0] a,
                             input logic [DW-1:0] d, input logic [WBW-1:0] w,
                             input logic [MW-1:0] m, input logic z, input logic [RW-1:0] r);
    ex_bpc = b; ex_alu_out = a; ex_rd2 = d; ex_ctlwb = w; ex_ctlm = m; ex_alu_zero = z; ex_rd = r;
  endtask

  // Advance one clock: capacity-2 FIFO model for SKID=1, capacity-1 for SKID=0.
  task automatic tick();
    logic a1, a0, p1, p0;
    logic [PW-1:0] w;
    a1 = ex_valid && exp_rdy1();
    a0 = ex_valid && exp_rdy0();
    p1 = (q1.size() > 0) && mem_ready;
    p0 = (q0.size() > 0) && mem_ready;
    w  = in_word();
    @(posedge clk);
    if (rst) begin
      q1.delete(); q0.delete(); last1 = '0; last0 = '0;
    end else if (flush) begin
      q1.delete(); q0.delete();
    end else begin
      if (p1) void'(q1.pop_front());
      if (a1) q1.push_back(w);
      if (p0) void'(q0.pop_front());
      if (a0) q0.push_back(w);
    end
    if (q1.size() > 0) last1 = q1[0];
    if (q0.size() > 0) last0 = q0[0];
    #1;
  endtask

  task automatic test_reset();
    set_payload(32'hdead, 32'hbeef, 32'h1234, 2'd3, 3'd7, 1'b1, 5'd31);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'hbeef);
    tick();
    tick();
    n_cmp++;
    if (obs1() !== '0) begin n_fail++; $display("FAIL reset_out1: got %h expected 0", obs1()); end
    n_cmp++;
    if (obs0() !== '0) begin n_fail++; $display("FAIL reset_out0: got %h expected 0", obs0()); end
    n_cmp++;
    if (rdy1 !== 1'b0 || rdy0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %b%b expected 00", rdy1, rdy0);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'hbeef);
    #1;
    n_cmp++;
    if (rdy1 !== 1'b1 || rdy0 !== 1'b1) begin
      n_fail++; $display("FAIL release_ready: got %b%b expected 11", rdy1, rdy0);
    end
  endtask

  task automatic test_pass_through();
    logic [PW:0] want;
    set_payload(32'd1, 32'd2, 32'd3, 2'd1, 3'd5, 1'b1, 5'd6);
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'd2);
    tick();
    want = {1'b1, 32'd1, 32'd2, 32'd3, 2'd1, 3'd5, 1'b1, 5'd6};
    n_cmp++;
    if (obs1() !== want) begin n_fail++; $display("FAIL pass1: got %h expected %h", obs1(), want); end
    n_cmp++;
    if (obs0() !== want) begin n_fail++; $display("FAIL pass0: got %h expected %h", obs0(), want); end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'd9);
    tick();
    n_cmp++;
    if (v1 !== 1'b0 || wb1 !== 2'd0 || m1 !== 3'd0 || bpc1 !== 32'd1) begin
      n_fail++; $display("FAIL bubble1: got v=%b wb=%h m=%h bpc=%h expected v=0 wb=0 m=0 bpc=1",
                         v1, wb1, m1, bpc1);
    end
    n_cmp++;
    if (v0 !== 1'b0 || wb0 !== 2'd0 || m0 !== 3'd0 || bpc0 !== 32'd1) begin
      n_fail++; $display("FAIL bubble0: got v=%b wb=%h m=%h bpc=%h expected v=0 wb=0 m=0 bpc=1",
                         v0, wb0, m0, bpc0);
    end
  endtask

  task automatic test_backpressure();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h10); tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h20); tick();
    n_cmp++;
    if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b expected 0", rdy1); end
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h30); tick();
    n_cmp++;
    if (v1 !== 1'b1 || alu1 !== 32'h10 || rdy1 !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold: got v=%b alu=%h rdy=%b expected v=1 alu=10 rdy=0", v1, alu1, rdy1);
    end
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h30); tick();
    n_cmp++;
    if (v1 !== 1'b1 || alu1 !== 32'h20) begin
      n_fail++; $display("FAIL bp_second: got v=%b alu=%h expected v=1 alu=20", v1, alu1);
    end
    tick();
    n_cmp++;
    if (v1 !== 1'b1 || alu1 !== 32'h30) begin
      n_fail++; $display("FAIL bp_third: got v=%b alu=%h expected v=1 alu=30", v1, alu1);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0); tick();
    n_cmp++;
    if (v1 !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", v1); end
  endtask

  task automatic test_flush();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h10); tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h20); tick();
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h30); tick();
    n_cmp++;
    if (v1 !== 1'b0 || rdy1 !== 1'b1 || v0 !== 1'b0) begin
      n_fail++; $display("FAIL flush: got v1=%b rdy1=%b v0=%b expected 0 1 0", v1, rdy1, v0);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (v1 !== 1'b0) begin n_fail++; $display("FAIL flush_stays_empty: got %b expected 0", v1); end
    end
  endtask

  task automatic test_skid0();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'haa); tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'haa); #1;
    n_cmp++;
    if (rdy0 !== 1'b0) begin n_fail++; $display("FAIL s0_ready_low: got %b expected 0", rdy0); end
    mem_ready = 1'b1; #1;
    n_cmp++;
    if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL s0_ready_high: got %b expected 1", rdy0); end
    for (int unsigned i = 1; i <= 4; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b1, DW'(i)); tick();
      n_cmp++;
      if (v0 !== 1'b1 || alu0 !== DW'(i)) begin
        n_fail++; $display("FAIL s0_b2b: got v=%b alu=%h expected v=1 alu=%h", v0, alu0, DW'(i));
      end
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0); tick();
    n_cmp++;
    if (v0 !== 1'b0) begin n_fail++; $display("FAIL s0_drain: got %b expected 0", v0); end
  endtask

  task automatic test_reset_mid();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h10); tick();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h20); tick();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 32'h30); tick();
    n_cmp++;
    if (obs1() !== '0) begin n_fail++; $display("FAIL rst_mid_clear: got %h expected 0", obs1()); end
    set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h55); tick();
    n_cmp++;
    if (v1 !== 1'b1 || alu1 !== 32'h55) begin
      n_fail++; $display("FAIL rst_mid_resume: got v=%b alu=%h expected v=1 alu=55", v1, alu1);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0); tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_payload($urandom, $urandom, $urandom, WBW'($urandom_range(0, 3)),
                  MW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), RW'($urandom_range(0, 31)));
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      ex_valid  = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 2) != 0);
      #1;
      n_cmp++;
      if (rdy1 !== exp_rdy1() || rdy0 !== exp_rdy0()) begin
        n_fail++; $display("FAIL rand_ready: got %b%b expected %b%b", rdy1, rdy0, exp_rdy1(), exp_rdy0());
      end
      tick();
      n_cmp++;
      if (obs1() !== exp1()) begin n_fail++; $display("FAIL rand_out1: got %h expected %h", obs1(), exp1()); end
      n_cmp++;
      if (obs0() !== exp0()) begin n_fail++; $display("FAIL rand_out0: got %h expected %h", obs0(), exp0()); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    last1 = '0;
    last0 = '0;
    set_payload('0, '0, '0, '0, '0, 1'b0, '0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, '0);
    test_reset();
    test_pass_through();
    test_backpressure();
    test_flush();
    test_skid0();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
